hazard_stall_unit: RTL and testbench
====================================

// Module: hazard_stall_unit
// PURPOSE
//  Parametrised load-use hazard and pipeline-freeze controller for the 5-stage pipelined CPU.
//  - Sits beside the ID stage and drives PC write enable, IF/ID hold and ID/EX bubble insertion.
//  - Supports multi-cycle load-use latency (LOAD_LAT bubbles) and operand-use qualification.
//  - Supports x0 exclusion and a whole-pipeline freeze while data memory is busy.
//  - Provides saturating stall/bubble performance counters.
// PARAMETERS
//  ADDR_W        5   register address width
//  LOAD_LAT      1   bubbles inserted per load-use hazard (0..7; 0 = never stall on load-use)
//  ZERO_REG_SAFE 1   1: rd==0 never creates a hazard
//  PERF_W        32  width of performance counters
// PORTS
//  clk_i         in   1       clock, rising edge
//  rst_n_i       in   1       asynchronous reset, active-low
//  EX_MemRead_i  in   1       instruction in EX is a load
//  EX_RDaddr_i   in   ADDR_W  destination register of EX instruction
//  ID_RS1addr_i  in   ADDR_W  rs1 of ID instruction
//  ID_RS1use_i   in   1       ID instruction reads rs1
//  ID_RS2addr_i  in   ADDR_W  rs2 of ID instruction
//  ID_RS2use_i   in   1       ID instruction reads rs2
//  MEM_busy_i    in   1       data memory not ready; freeze the whole pipeline
//  PCWrite_o     out  1       PC update enable
//  Stall_o       out  1       hold IF/ID register
//  NoOp_o        out  1       zero ID/EX control (insert bubble)
//  Freeze_o      out  1       hold ID/EX, EX/MEM, MEM/WB registers
//  stall_cnt_o   out  PERF_W  cycles with Stall_o=1, saturating
//  bubble_cnt_o  out  PERF_W  cycles with NoOp_o=1, saturating
// BEHAVIOUR
//  - hit = EX_MemRead_i & ((ID_RS1use_i & RS1==RD) | (ID_RS2use_i & RS2==RD)) & ~(ZERO_REG_SAFE & RD==0).
//    hit is forced to 0 when LOAD_LAT==0.
//  - States: IDLE, LU_STALL. 3-bit remaining-bubble counter rem.
//  - Priority 1, MEM_busy_i=1 (any state):
//    - Outputs: PCWrite=0, Stall=1, Freeze=1, NoOp=0.
//    - State and rem are held; hit is ignored.
//  - Priority 2, IDLE with hit:
//    - Combinational outputs in the same cycle: PCWrite=0, Stall=1, NoOp=1, Freeze=0.
//    - If LOAD_LAT>1: next state LU_STALL, rem=LOAD_LAT-1. Otherwise stay in IDLE.
//  - Priority 3, LU_STALL:
//    - Outputs: PCWrite=0, Stall=1, NoOp=1, Freeze=0. New hits are ignored.
//    - rem decrements each cycle; when rem==1, next state is IDLE.
//    - Total bubbles per hazard = LOAD_LAT exactly.
//  - Otherwise (IDLE, no hit): PCWrite=1, Stall=0, NoOp=0, Freeze=0.
//  - Outputs PCWrite/Stall/NoOp/Freeze are combinational from state and inputs. Zero added latency on detection.
//  - Counters:
//    - stall_cnt_o increments on each clock edge where Stall_o=1.
//    - bubble_cnt_o increments on each clock edge where NoOp_o=1.
//    - Both saturate at 2^PERF_W-1 and never wrap.
//  - Reset (async, any time incl. mid-LU_STALL):
//    - state=IDLE, rem=0, both counters=0.
//    - Outputs immediately PCWrite=1, Stall=0, NoOp=0, Freeze=0 (while inputs show no hazard or busy).
//  - Simultaneous MEM_busy_i and hit in IDLE: freeze wins. Hit is re-evaluated the cycle busy drops.
// TESTING
//  1. LOAD_LAT=1: MemRead=1, RD=5, RS1=5, RS1use=1 for 1 cycle -> that cycle PCWrite=0/Stall=1/NoOp=1.
//     Next cycle (MemRead=0) all released; bubble_cnt=1.
//  2. RD=0=RS1 with MemRead=1 -> no stall.
//     RD=7=RS2 with RS2use=0 -> no stall.
//     RD=7=RS2 with RS2use=1 -> stall.
//  3. LOAD_LAT=3: hit at cycle t -> NoOp=1 on t, t+1, t+2; released at t+3.
//     stall_cnt=3, bubble_cnt=3.
//  4. LOAD_LAT=3: MEM_busy=1 for 2 cycles starting t+1 -> Freeze=1, NoOp=0, rem held.
//     Bubbles end at t+4; stall_cnt=5, bubble_cnt=3.
//  5. rst_n_i low mid-LU_STALL (not on a clock edge) -> outputs default immediately, counters 0.
//     After release, no residual bubbles.
//  6. PERF_W=4: hold a hazard for 20 stall cycles -> stall_cnt_o reaches 15 and stays at 15.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// ============================================================================
// Module      : hazard_stall_unit_if
// Description : ID-stage hazard inputs and pipeline control outputs for the
//               load-use hazard / freeze controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_unit_if #(
  parameter int ADDR_W = 5,
  parameter int PERF_W = 32
);
  logic              EX_MemRead_i;
  logic [ADDR_W-1:0] EX_RDaddr_i;
  logic [ADDR_W-1:0] ID_RS1addr_i;
  logic              ID_RS1use_i;
  logic [ADDR_W-1:0] ID_RS2addr_i;
  logic              ID_RS2use_i;
  logic              MEM_busy_i;
  logic              PCWrite_o;
  logic              Stall_o;
  logic              NoOp_o;
  logic              Freeze_o;
  logic [PERF_W-1:0] stall_cnt_o;
  logic [PERF_W-1:0] bubble_cnt_o;

  // Pipeline side: supplies operand/destination info, consumes controls
  modport master (
    output EX_MemRead_i, EX_RDaddr_i, ID_RS1addr_i, ID_RS1use_i,
           ID_RS2addr_i, ID_RS2use_i, MEM_busy_i,
    input  PCWrite_o, Stall_o, NoOp_o, Freeze_o, stall_cnt_o, bubble_cnt_o
  );

  // Controller side
  modport slave (
    input  EX_MemRead_i, EX_RDaddr_i, ID_RS1addr_i, ID_RS1use_i,
           ID_RS2addr_i, ID_RS2use_i, MEM_busy_i,
    output PCWrite_o, Stall_o, NoOp_o, Freeze_o, stall_cnt_o, bubble_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_unit.sv
// ============================================================================
// Module      : hazard_stall_unit
// Description : Load-use hazard detector and pipeline freeze controller with
//               multi-cycle bubble insertion and saturating perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_unit #(
  parameter int ADDR_W        = 5,
  parameter int LOAD_LAT      = 1,
  parameter int ZERO_REG_SAFE = 1,
  parameter int PERF_W        = 32
) (
  input  wire logic          clk_i,
  input  wire logic          rst_n_i,
  hazard_stall_unit_if.slave bus
);

  // Bubbles still owed after the first one, loaded on entry to LU_STALL
  localparam logic [2:0] c_REM_INIT = 3'((LOAD_LAT > 1) ? (LOAD_LAT - 1) : 0);
  localparam logic [PERF_W-1:0] c_CNT_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_LU_STALL = 1'b1
  } state_t;

  state_t            r_state;
  logic [2:0]        r_rem;
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_bubble_cnt;

  logic [ADDR_W-1:0] w_rd;
  logic              w_rs1_match;
  logic              w_rs2_match;
  logic              w_rd_zero_safe;
  logic              w_hit;
  logic              w_pcwrite;
  logic              w_stall;
  logic              w_noop;
  logic              w_freeze;

  assign w_rd           = bus.EX_RDaddr_i;
  assign w_rs1_match    = bus.ID_RS1use_i && (bus.ID_RS1addr_i == w_rd);
  assign w_rs2_match    = bus.ID_RS2use_i && (bus.ID_RS2addr_i == w_rd);
  assign w_rd_zero_safe = (ZERO_REG_SAFE != 0) && (w_rd == '0);
  // A zero latency build never stalls on a load-use dependency
  assign w_hit          = (LOAD_LAT != 0) && bus.EX_MemRead_i &&
                          (w_rs1_match || w_rs2_match) && !w_rd_zero_safe;

  // Control outputs: memory freeze dominates, then bubble insertion
  always_comb begin
    w_pcwrite = 1'b1;
    w_stall   = 1'b0;
    w_noop    = 1'b0;
    w_freeze  = 1'b0;
    if (bus.MEM_busy_i) begin
      w_pcwrite = 1'b0;
      w_stall   = 1'b1;
      w_freeze  = 1'b1;
    end else if ((r_state == S_LU_STALL) || w_hit) begin
      w_pcwrite = 1'b0;
      w_stall   = 1'b1;
      w_noop    = 1'b1;
    end
  end

  // Bubble sequencer; state and remaining count hold while memory is busy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_rem   <= 3'd0;
    end else if (!bus.MEM_busy_i) begin
      case (r_state)
        S_IDLE: begin
          if (w_hit && (LOAD_LAT > 1)) begin
            r_state <= S_LU_STALL;
            r_rem   <= c_REM_INIT;
          end
        end
        S_LU_STALL: begin
          if (r_rem <= 3'd1) begin
            r_state <= S_IDLE;
            r_rem   <= 3'd0;
          end else begin
            r_rem   <= r_rem - 3'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_rem   <= 3'd0;
        end
      endcase
    end
  end

  // Saturating performance counters for stall and bubble cycles
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
      if (w_noop && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + c_CNT_ONE;
      end
    end
  end

  assign bus.PCWrite_o    = w_pcwrite;
  assign bus.Stall_o      = w_stall;
  assign bus.NoOp_o       = w_noop;
  assign bus.Freeze_o     = w_freeze;
  assign bus.stall_cnt_o  = r_stall_cnt;
  assign bus.bubble_cnt_o = r_bubble_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
// ============================================================================
// Module      : tb_hazard_stall_unit
// Description : Directed bench for hazard_stall_unit. Three instances share
//               stimulus: LOAD_LAT=1, LOAD_LAT=3, and LOAD_LAT=3 with 4-bit
//               counters. A bubble-debt model is compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       t_mr = 1'b0, t_u1 = 1'b0, t_u2 = 1'b0, t_busy = 1'b0;
  logic [4:0] t_rd = '0, t_rs1 = '0, t_rs2 = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.ADDR_W(5), .PERF_W(32)) if0 ();
  hazard_stall_unit_if #(.ADDR_W(5), .PERF_W(32)) if1 ();
  hazard_stall_unit_if #(.ADDR_W(5), .PERF_W(4))  if2 ();

  assign if0.EX_MemRead_i = t_mr;   assign if1.EX_MemRead_i = t_mr;   assign if2.EX_MemRead_i = t_mr;
  assign if0.EX_RDaddr_i  = t_rd;   assign if1.EX_RDaddr_i  = t_rd;   assign if2.EX_RDaddr_i  = t_rd;
  assign if0.ID_RS1addr_i = t_rs1;  assign if1.ID_RS1addr_i = t_rs1;  assign if2.ID_RS1addr_i = t_rs1;
  assign if0.ID_RS1use_i  = t_u1;   assign if1.ID_RS1use_i  = t_u1;   assign if2.ID_RS1use_i  = t_u1;
  assign if0.ID_RS2addr_i = t_rs2;  assign if1.ID_RS2addr_i = t_rs2;  assign if2.ID_RS2addr_i = t_rs2;
  assign if0.ID_RS2use_i  = t_u2;   assign if1.ID_RS2use_i  = t_u2;   assign if2.ID_RS2use_i  = t_u2;
  assign if0.MEM_busy_i   = t_busy; assign if1.MEM_busy_i   = t_busy; assign if2.MEM_busy_i   = t_busy;

  hazard_stall_unit #(.ADDR_W(5), .LOAD_LAT(1), .ZERO_REG_SAFE(1), .PERF_W(32))
    u0 (.clk_i(clk), .rst_n_i(rst_n), .bus(if0.slave));
  hazard_stall_unit #(.ADDR_W(5), .LOAD_LAT(3), .ZERO_REG_SAFE(1), .PERF_W(32))
    u1 (.clk_i(clk), .rst_n_i(rst_n), .bus(if1.slave));
  hazard_stall_unit #(.ADDR_W(5), .LOAD_LAT(3), .ZERO_REG_SAFE(1), .PERF_W(4))
    u2 (.clk_i(clk), .rst_n_i(rst_n), .bus(if2.slave));

  // Flattened view of the three instances' outputs
  logic        o_pc[3], o_st[3], o_no[3], o_fr[3];
  logic [31:0] o_sc[3], o_bc[3];
  assign o_pc[0] = if0.PCWrite_o;  assign o_pc[1] = if1.PCWrite_o;  assign o_pc[2] = if2.PCWrite_o;
  assign o_st[0] = if0.Stall_o;    assign o_st[1] = if1.Stall_o;    assign o_st[2] = if2.Stall_o;
  assign o_no[0] = if0.NoOp_o;     assign o_no[1] = if1.NoOp_o;     assign o_no[2] = if2.NoOp_o;
  assign o_fr[0] = if0.Freeze_o;   assign o_fr[1] = if1.Freeze_o;   assign o_fr[2] = if2.Freeze_o;
  assign o_sc[0] = if0.stall_cnt_o;  assign o_sc[1] = if1.stall_cnt_o;  assign o_sc[2] = {28'd0, if2.stall_cnt_o};
  assign o_bc[0] = if0.bubble_cnt_o; assign o_bc[1] = if1.bubble_cnt_o; assign o_bc[2] = {28'd0, if2.bubble_cnt_o};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: bubbles owed per instance ----------
  int    c_lat[3] = '{1, 3, 3};
  longint c_max[3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
  int     owe[3], n_owe[3];
  longint m_sc[3], m_bc[3], n_sc[3], n_bc[3];

  // Compare on the falling edge, and work out what each counter/debt becomes
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic hit, e_pc, e_st, e_no, e_fr;
      longint e_sc, e_bc;
      int nx;
      hit  = t_mr && ((t_u1 && t_rs1 == t_rd) || (t_u2 && t_rs2 == t_rd)) &&
             (t_rd != 0) && (c_lat[k] != 0);
      e_pc = 1'b1; e_st = 1'b0; e_no = 1'b0; e_fr = 1'b0;
      e_sc = m_sc[k]; e_bc = m_bc[k]; nx = 0;
      if (!rst_n) begin
        e_sc = 0; e_bc = 0;
      end else if (t_busy) begin
        e_pc = 1'b0; e_st = 1'b1; e_fr = 1'b1; nx = owe[k];
      end else if (owe[k] > 0 || hit) begin
        e_pc = 1'b0; e_st = 1'b1; e_no = 1'b1;
        nx = (owe[k] > 0) ? owe[k] - 1 : c_lat[k] - 1;
      end
      chk($sformatf("u%0d.PCWrite", k), 64'(o_pc[k]), 64'(e_pc));
      chk($sformatf("u%0d.Stall", k),   64'(o_st[k]), 64'(e_st));
      chk($sformatf("u%0d.NoOp", k),    64'(o_no[k]), 64'(e_no));
      chk($sformatf("u%0d.Freeze", k),  64'(o_fr[k]), 64'(e_fr));
      chk($sformatf("u%0d.stall_cnt", k),  64'(o_sc[k]), e_sc);
      chk($sformatf("u%0d.bubble_cnt", k), 64'(o_bc[k]), e_bc);
      n_owe[k] <= nx;
      n_sc[k]  <= (!rst_n) ? 0 : (e_st ? ((e_sc < c_max[k]) ? e_sc + 1 : e_sc) : e_sc);
      n_bc[k]  <= (!rst_n) ? 0 : (e_no ? ((e_bc < c_max[k]) ? e_bc + 1 : e_bc) : e_bc);
    end
  end

  // Model state advances on the clock, clears on reset
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        owe[k] <= 0; m_sc[k] <= 0; m_bc[k] <= 0;
      end else begin
        owe[k] <= n_owe[k]; m_sc[k] <= n_sc[k]; m_bc[k] <= n_bc[k];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic u1, input logic [4:0] rs2, input logic u2, input logic busy);
    t_mr = mr; t_rd = rd; t_rs1 = rs1; t_u1 = u1; t_rs2 = rs2; t_u2 = u2; t_busy = busy;
  endtask

  task automatic idle_in();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst_n = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_in();
    #2;
    chk("reset.PCWrite", 64'(o_pc[0]), 64'd1);
    chk("reset.stall_cnt", 64'(o_sc[1]), 64'd0);
    #11 rst_n = 1'b1;

    // 1: single-bubble load-use on rs1
    step(); drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    chk("t1.hit_PCWrite", 64'(o_pc[0]), 64'd0);
    chk("t1.hit_NoOp", 64'(o_no[0]), 64'd1);
    step(); idle_in(); #1;
    chk("t1.release_Stall", 64'(o_st[0]), 64'd0);
    chk("t1.bubble_cnt", 64'(o_bc[0]), 64'd1);

    // 2: x0 exclusion and operand-use qualification
    do_reset();
    step(); drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    chk("t2.x0_Stall", 64'(o_st[0]), 64'd0);
    step(); drive(1'b1, 5'd7, 5'd1, 1'b0, 5'd7, 1'b0, 1'b0); #1;
    chk("t2.rs2_unused_Stall", 64'(o_st[0]), 64'd0);
    step(); drive(1'b1, 5'd7, 5'd1, 1'b0, 5'd7, 1'b1, 1'b0); #1;
    chk("t2.rs2_used_Stall", 64'(o_st[0]), 64'd1);
    step(); idle_in();

    // 3: three bubbles for LOAD_LAT=3
    do_reset();
    step(); drive(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    chk("t3.t0_NoOp", 64'(o_no[1]), 64'd1);
    step(); idle_in(); #1;
    chk("t3.t1_NoOp", 64'(o_no[1]), 64'd1);
    step(); #1;
    chk("t3.t2_NoOp", 64'(o_no[1]), 64'd1);
    step(); #1;
    chk("t3.t3_PCWrite", 64'(o_pc[1]), 64'd1);
    chk("t3.stall_cnt", 64'(o_sc[1]), 64'd3);
    chk("t3.bubble_cnt", 64'(o_bc[1]), 64'd3);

    // 4: freeze in the middle of a multi-cycle stall
    do_reset();
    step(); drive(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
    step(); drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); #1;
    chk("t4.busy_Freeze", 64'(o_fr[1]), 64'd1);
    chk("t4.busy_NoOp", 64'(o_no[1]), 64'd0);
    step(); #1;
    step(); idle_in(); #1;
    chk("t4.t3_NoOp", 64'(o_no[1]), 64'd1);
    step(); #1;
    chk("t4.t4_NoOp", 64'(o_no[1]), 64'd1);
    step(); #1;
    chk("t4.t5_NoOp", 64'(o_no[1]), 64'd0);
    chk("t4.stall_cnt", 64'(o_sc[1]), 64'd5);
    chk("t4.bubble_cnt", 64'(o_bc[1]), 64'd3);

    // Busy together with a fresh hit: freeze wins, hit re-evaluated afterwards
    do_reset();
    step(); drive(1'b1, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1); #1;
    chk("t4b.busy_hit_NoOp", 64'(o_no[0]), 64'd0);
    step(); t_busy = 1'b0; #1;
    chk("t4b.after_busy_NoOp", 64'(o_no[0]), 64'd1);
    step(); idle_in();

    // 5: asynchronous reset in the middle of LU_STALL
    do_reset();
    step(); drive(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
    step(); idle_in();
    #2 rst_n = 1'b0;
    #1;
    chk("t5.rst_PCWrite", 64'(o_pc[1]), 64'd1);
    chk("t5.rst_NoOp", 64'(o_no[1]), 64'd0);
    chk("t5.rst_bubble_cnt", 64'(o_bc[1]), 64'd0);
    #3 rst_n = 1'b1;
    step(); #1;
    chk("t5.post_NoOp", 64'(o_no[1]), 64'd0);
    step(); #1;
    chk("t5.post2_NoOp", 64'(o_no[1]), 64'd0);

    // 6: counter saturation with 4-bit counters
    do_reset();
    step(); drive(1'b1, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0);
    repeat (20) step();
    #1;
    chk("t6.sat_stall_cnt", 64'(o_sc[2]), 64'd15);
    chk("t6.wide_stall_cnt", 64'(o_sc[0]), 64'd20);
    step(); #1;
    chk("t6.sat_hold", 64'(o_sc[2]), 64'd15);
    idle_in();
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
